// File: rtl/wb_timer_if.sv
// Wishbone classic slave bus bundle for wb_timer.
// The master modport drives the request side and the slave modport answers it.
interface wb_timer_if;
  logic [31:0] wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_we_i;
  logic        wb_ack_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    input  wb_dat_o, wb_ack_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_stb_i, wb_cyc_i, wb_we_i,
    output wb_dat_o, wb_ack_o
  );
endinterface

// File: rtl/wb_timer.sv
// Wishbone-attached 32-bit timer: prescaled counter with compare match, auto-reload
// or one-shot mode, registered level interrupt and a free-running cycle counter.
module wb_timer #(
  parameter int unsigned PRESCALE_W = 16
) (
  input  logic      clk_i,
  input  logic      rst_i,
  wb_timer_if.slave wb,
  output logic      intr_o
);

  typedef enum logic [2:0] {
    REG_CTRL     = 3'd0,
    REG_STAT     = 3'd1,
    REG_COMPARE  = 3'd2,
    REG_COUNTER  = 3'd3,
    REG_PRESCALE = 3'd4,
    REG_CYCLES   = 3'd5,
    REG_RSVD6    = 3'd6,
    REG_RSVD7    = 3'd7
  } reg_e;

  logic                  en_q, en_d;
  logic                  ar_q, ar_d;
  logic                  irqen_q, irqen_d;
  logic                  match_q, match_d;
  logic [31:0]           compare_q, compare_d;
  logic [31:0]           counter_q, counter_d;
  logic [31:0]           cycles_q, cycles_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  ack_q, ack_d;
  logic [31:0]           dat_q, dat_d;
  logic                  intr_q, intr_d;

  reg_e        reg_sel;
  logic        bus_req;
  logic        bus_wr;
  logic        tick;
  logic        hit;
  logic [31:0] rdata;
  logic        unused_adr;

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  sel);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (sel[b]) res[8*b +: 8] = new_v[8*b +: 8];
    end
    return res;
  endfunction

  assign reg_sel    = reg_e'(wb.wb_adr_i[4:2]);
  assign unused_adr = ^{wb.wb_adr_i[31:5], wb.wb_adr_i[1:0]};

  // A request is accepted only while no ack is pending, so a held strobe alternates.
  assign bus_req = wb.wb_stb_i & wb.wb_cyc_i & ~ack_q;
  assign bus_wr  = bus_req & wb.wb_we_i;

  assign tick = en_q && (pcnt_q == '0);
  assign hit  = (counter_q == compare_q);

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL:     rdata = {29'd0, irqen_q, ar_q, en_q};
      REG_STAT:     rdata = {31'd0, match_q};
      REG_COMPARE:  rdata = compare_q;
      REG_COUNTER:  rdata = counter_q;
      REG_PRESCALE: rdata = 32'(prescale_q);
      REG_CYCLES:   rdata = cycles_q;
      default:      rdata = '0;
    endcase
  end

  always_comb begin
    // NOTE: every next-state value defaults to its hold value first, so no path infers a latch.
    en_d       = en_q;
    ar_d       = ar_q;
    irqen_d    = irqen_q;
    match_d    = match_q;
    compare_d  = compare_q;
    counter_d  = counter_q;
    prescale_d = prescale_q;
    pcnt_d     = pcnt_q;
    cycles_d   = cycles_q + 32'd1;
    ack_d      = bus_req;
    dat_d      = (bus_req && !wb.wb_we_i) ? rdata : '0;
    intr_d     = match_q & irqen_q;

    if (en_q) begin
      pcnt_d = tick ? prescale_q : pcnt_q - PRESCALE_W'(1);
    end

    if (tick) begin
      if (hit) begin
        match_d = 1'b1;
        if (ar_q) counter_d = '0;
        else      en_d      = 1'b0;
      end else begin
        counter_d = counter_q + 32'd1;
      end
    end

    // Bus writes are applied after the timer event so the written value wins.
    if (bus_wr) begin
      case (reg_sel)
        REG_CTRL: begin
          if (wb.wb_sel_i[0]) begin
            en_d    = wb.wb_dat_i[0];
            ar_d    = wb.wb_dat_i[1];
            irqen_d = wb.wb_dat_i[2];
            if (!en_q && wb.wb_dat_i[0]) pcnt_d = prescale_q;
          end
        end
        REG_STAT: begin
          if (wb.wb_sel_i[0] && wb.wb_dat_i[0] && !(tick && hit)) match_d = 1'b0;
        end
        REG_COMPARE:  compare_d = merge_lanes(compare_q, wb.wb_dat_i, wb.wb_sel_i);
        REG_COUNTER:  counter_d = merge_lanes(counter_d, wb.wb_dat_i, wb.wb_sel_i);
        REG_PRESCALE: begin
          for (int i = 0; i < PRESCALE_W; i++) begin
            if (wb.wb_sel_i[i/8]) prescale_d[i] = wb.wb_dat_i[i];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst_i) begin
      en_q       <= 1'b0;
      ar_q       <= 1'b0;
      irqen_q    <= 1'b0;
      match_q    <= 1'b0;
      compare_q  <= 32'hFFFF_FFFF;
      counter_q  <= '0;
      cycles_q   <= '0;
      prescale_q <= '0;
      pcnt_q     <= '0;
      ack_q      <= 1'b0;
      dat_q      <= '0;
      intr_q     <= 1'b0;
    end else begin
      en_q       <= en_d;
      ar_q       <= ar_d;
      irqen_q    <= irqen_d;
      match_q    <= match_d;
      compare_q  <= compare_d;
      counter_q  <= counter_d;
      cycles_q   <= cycles_d;
      prescale_q <= prescale_d;
      pcnt_q     <= pcnt_d;
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      intr_q     <= intr_d;
    end
  end

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign intr_o      = intr_q;

endmodule

// File: tb/tb_wb_timer.sv
// Self-checking bench for wb_timer: register table, cycle-exact corner sequences,
// and randomized bus traffic checked every cycle against a reference model.
module tb_wb_timer;
  localparam int unsigned PW = 16;

  logic clk_i;
  logic rst_i;
  logic intr_o;
  wb_timer_if bus ();

  wb_timer #(.PRESCALE_W(PW)) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wb     (bus),
    .intr_o (intr_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] sel);
    logic [31:0] mask;
    mask = {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // Reference model: architectural registers plus "cycles left until the next tick".
  logic        m_en = 0, m_ar = 0, m_irq = 0, m_match = 0;
  logic        m_ack = 0, m_rd = 0, m_intr = 0;
  logic [31:0] m_cmp = '1, m_cnt = 0, m_cyc = 0, m_dat = 0;
  logic [15:0] m_pre = 0, m_left = 0;

  task automatic model_step();
    logic        req, wr, tick, hit, old_en;
    logic [2:0]  idx;
    logic [31:0] rv, wd, tmp;
    logic [3:0]  sel;
    if (rst_i) begin
      m_en = 0; m_ar = 0; m_irq = 0; m_match = 0; m_ack = 0; m_rd = 0; m_intr = 0;
      m_cmp = '1; m_cnt = 0; m_cyc = 0; m_dat = 0; m_pre = 0; m_left = 0;
      return;
    end
    idx = bus.wb_adr_i[4:2];
    wd  = bus.wb_dat_i;
    sel = bus.wb_sel_i;
    req = bus.wb_stb_i && bus.wb_cyc_i && !m_ack;
    wr  = req && bus.wb_we_i;
    case (idx)
      3'd0:    rv = {29'd0, m_irq, m_ar, m_en};
      3'd1:    rv = {31'd0, m_match};
      3'd2:    rv = m_cmp;
      3'd3:    rv = m_cnt;
      3'd4:    rv = {16'd0, m_pre};
      3'd5:    rv = m_cyc;
      default: rv = 0;
    endcase
    m_intr = m_match && m_irq;
    m_ack  = req;
    m_rd   = req && !bus.wb_we_i;
    m_dat  = m_rd ? rv : 32'd0;
    m_cyc  = m_cyc + 1;
    old_en = m_en;
    tick   = m_en && (m_left == 0);
    hit    = tick && (m_cnt == m_cmp);
    if (m_en) m_left = tick ? m_pre : m_left - 16'd1;
    if (tick && !hit) m_cnt = m_cnt + 1;
    if (hit) begin
      m_match = 1;
      if (m_ar) m_cnt = 0;
      else      m_en  = 0;
    end
    if (wr) begin
      case (idx)
        3'd0: if (sel[0]) begin
          if (!old_en && wd[0]) m_left = m_pre;
          m_en = wd[0]; m_ar = wd[1]; m_irq = wd[2];
        end
        3'd1: if (sel[0] && wd[0] && !hit) m_match = 0;
        3'd2: m_cmp = lanes(m_cmp, wd, sel);
        3'd3: m_cnt = lanes(m_cnt, wd, sel);
        3'd4: begin tmp = lanes({16'd0, m_pre}, wd, sel); m_pre = tmp[15:0]; end
        default: ;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk_i);
    model_step();
  end

  initial forever begin
    @(negedge clk_i);
    check("mon_ack", 32'(bus.wb_ack_o), 32'(m_ack));
    check("mon_intr", 32'(intr_o), 32'(m_intr));
    if (m_ack && m_rd) check("mon_rdata", bus.wb_dat_o, m_dat);
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_i); #1; end
  endtask

  task automatic bus_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, output logic [31:0] rdat);
    bit got;
    got = 0;
    bus.wb_we_i = we; bus.wb_adr_i = adr; bus.wb_dat_i = dat; bus.wb_sel_i = sel;
    bus.wb_stb_i = 1; bus.wb_cyc_i = 1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(posedge clk_i); #1;
      if (bus.wb_ack_o) got = 1;
    end
    rdat = bus.wb_dat_o;
    bus.wb_stb_i = 0; bus.wb_cyc_i = 0; bus.wb_we_i = 0;
    if (!got) check("ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic wb_write(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    logic [31:0] unused_rd;
    bus_xfer(1'b1, adr, dat, sel, unused_rd);
    idle(1);
  endtask

  task automatic wb_read(input logic [31:0] adr, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    bus_xfer(1'b0, adr, 32'd0, 4'hF, rd);
    check(name, rd, exp);
    idle(1);
  endtask

  task automatic do_reset();
    rst_i = 1; idle(1); rst_i = 0;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input logic [31:0] exp);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.exp = exp;
    return v;
  endfunction

  initial begin
    vec_t        tbl[$];
    logic [31:0] rd, d, adr;
    logic [2:0]  idx;
    int          acks;

    rst_i = 1;
    bus.wb_adr_i = 0; bus.wb_dat_i = 0; bus.wb_sel_i = 0;
    bus.wb_stb_i = 0; bus.wb_cyc_i = 0; bus.wb_we_i = 0;

    tbl.push_back(mk(0, 32'h00, 32'h0,         4'hF, 32'h0));
    tbl.push_back(mk(0, 32'h04, 32'h0,         4'hF, 32'h0));
    tbl.push_back(mk(0, 32'h08, 32'h0,         4'hF, 32'hFFFF_FFFF));
    tbl.push_back(mk(0, 32'h0C, 32'h0,         4'hF, 32'h0));
    tbl.push_back(mk(0, 32'h10, 32'h0,         4'hF, 32'h0));
    tbl.push_back(mk(1, 32'h08, 32'h0000_AB00, 4'h2, 32'h0));
    tbl.push_back(mk(0, 32'h08, 32'h0,         4'hF, 32'hFFFF_ABFF));
    tbl.push_back(mk(1, 32'h0C, 32'h1234_5678, 4'hF, 32'h0));
    tbl.push_back(mk(1, 32'h0C, 32'h0000_00AA, 4'h1, 32'h0));
    tbl.push_back(mk(0, 32'h0C, 32'h0,         4'hF, 32'h1234_56AA));
    tbl.push_back(mk(1, 32'h10, 32'hFFFF_FFFF, 4'hF, 32'h0));
    tbl.push_back(mk(0, 32'h10, 32'h0,         4'hF, 32'h0000_FFFF));
    tbl.push_back(mk(1, 32'h10, 32'h0,         4'h2, 32'h0));
    tbl.push_back(mk(0, 32'h10, 32'h0,         4'hF, 32'h0000_00FF));
    tbl.push_back(mk(1, 32'h00, 32'hFFFF_FF06, 4'h1, 32'h0));
    tbl.push_back(mk(0, 32'h00, 32'h0,         4'hF, 32'h6));
    tbl.push_back(mk(1, 32'h00, 32'h0000_0001, 4'hE, 32'h0));
    tbl.push_back(mk(0, 32'h00, 32'h0,         4'hF, 32'h6));
    tbl.push_back(mk(1, 32'h1C, 32'hFFFF_FFFF, 4'hF, 32'h0));
    tbl.push_back(mk(0, 32'h1C, 32'h0,         4'hF, 32'h0));
    tbl.push_back(mk(0, 32'h18, 32'h0,         4'hF, 32'h0));
    tbl.push_back(mk(1, 32'h04, 32'h1,         4'h1, 32'h0));
    tbl.push_back(mk(0, 32'h04, 32'h0,         4'hF, 32'h0));
    tbl.push_back(mk(0, 32'hFFFF_FFEB, 32'h0,  4'hF, 32'hFFFF_ABFF));
    tbl.push_back(mk(1, 32'h0C, 32'h0,         4'h0, 32'h0));
    tbl.push_back(mk(0, 32'h0C, 32'h0,         4'hF, 32'h1234_56AA));
    tbl.push_back(mk(1, 32'h00, 32'h0,         4'h1, 32'h0));

    idle(1);
    check("rst_ack", 32'(bus.wb_ack_o), 32'd0);
    check("rst_intr", 32'(intr_o), 32'd0);
    check("rst_dat", bus.wb_dat_o, 32'd0);
    rst_i = 0;

    foreach (tbl[i]) begin
      if (tbl[i].we) wb_write(tbl[i].adr, tbl[i].dat, tbl[i].sel);
      else           wb_read(tbl[i].adr, tbl[i].exp, $sformatf("tbl%0d", i));
    end

    // Auto-reload with prescale 0: match on the 4th tick, interrupt one cycle later.
    do_reset();
    wb_write(32'h10, 32'd0, 4'hF);
    wb_write(32'h08, 32'd3, 4'hF);
    wb_write(32'h00, 32'h7, 4'h1);
    idle(3); check("ar_intr_before", 32'(intr_o), 32'd0);
    idle(1); check("ar_intr_after", 32'(intr_o), 32'd1);
    wb_read(32'h04, 32'd1, "ar_match");
    wb_read(32'h0C, 32'd3, "ar_counter");
    wb_write(32'h00, 32'h0, 4'h1);

    // One-shot with prescale 4: one tick every 5 cycles, stops at COMPARE.
    do_reset();
    wb_write(32'h10, 32'd4, 4'hF);
    wb_write(32'h08, 32'd2, 4'hF);
    wb_write(32'h00, 32'h1, 4'h1);
    idle(3);
    wb_read(32'h0C, 32'd0, "os_cnt_t5");
    wb_read(32'h0C, 32'd1, "os_cnt_t7");
    idle(2);
    wb_read(32'h0C, 32'd2, "os_cnt_t11");
    wb_read(32'h00, 32'd1, "os_en_before");
    wb_read(32'h04, 32'd0, "os_match_before");
    wb_read(32'h00, 32'd0, "os_en_after");
    wb_read(32'h04, 32'd1, "os_match_after");
    wb_read(32'h0C, 32'd2, "os_cnt_stop");
    check("os_intr", 32'(intr_o), 32'd0);
    idle(10);
    wb_read(32'h0C, 32'd2, "os_cnt_hold");
    check("os_intr_hold", 32'(intr_o), 32'd0);

    // Counter wraps through zero without a match, then matches at 5.
    do_reset();
    wb_write(32'h0C, 32'hFFFF_FFFE, 4'hF);
    wb_write(32'h08, 32'd5, 4'hF);
    wb_write(32'h10, 32'd0, 4'hF);
    wb_write(32'h00, 32'h1, 4'h1);
    wb_read(32'h0C, 32'hFFFF_FFFF, "wrap_cnt_max");
    wb_read(32'h04, 32'd0, "wrap_no_match");
    wb_read(32'h0C, 32'd3, "wrap_cnt_3");
    wb_read(32'h04, 32'd0, "wrap_match_pre");
    wb_read(32'h04, 32'd1, "wrap_match_post");
    wb_read(32'h0C, 32'd5, "wrap_cnt_5");
    wb_read(32'h00, 32'd0, "wrap_en_off");

    // STAT clear on the exact match edge loses; a later clear drops intr_o a cycle after.
    do_reset();
    wb_write(32'h10, 32'd0, 4'hF);
    wb_write(32'h08, 32'd3, 4'hF);
    wb_write(32'h00, 32'h7, 4'h1);
    idle(6);
    wb_write(32'h04, 32'h1, 4'h1);
    wb_read(32'h04, 32'd1, "w1c_set_wins");
    wb_write(32'h00, 32'h4, 4'h1);
    bus_xfer(1'b1, 32'h04, 32'h1, 4'h1, rd);
    check("w1c_intr_hold", 32'(intr_o), 32'd1);
    idle(1);
    check("w1c_intr_fall", 32'(intr_o), 32'd0);
    wb_read(32'h04, 32'd0, "w1c_cleared");

    // Held strobe for six edges yields three acknowledges.
    acks = 0;
    bus.wb_adr_i = 32'h04; bus.wb_we_i = 0; bus.wb_sel_i = 4'hF;
    bus.wb_stb_i = 1; bus.wb_cyc_i = 1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_i); #1;
      if (bus.wb_ack_o) acks++;
    end
    bus.wb_stb_i = 0; bus.wb_cyc_i = 0;
    check("held_stb_acks", 32'(acks), 32'd3);
    idle(1);

    // Reset during a run with MATCH set, with a write in flight that must be dropped.
    do_reset();
    wb_write(32'h10, 32'd0, 4'hF);
    wb_write(32'h08, 32'd3, 4'hF);
    wb_write(32'h00, 32'h7, 4'h1);
    idle(6);
    check("rr_intr_pre", 32'(intr_o), 32'd1);
    rst_i = 1;
    bus.wb_adr_i = 32'h08; bus.wb_dat_i = 32'h55; bus.wb_sel_i = 4'hF;
    bus.wb_we_i = 1; bus.wb_stb_i = 1; bus.wb_cyc_i = 1;
    idle(1);
    check("rr_ack", 32'(bus.wb_ack_o), 32'd0);
    check("rr_intr", 32'(intr_o), 32'd0);
    check("rr_dat", bus.wb_dat_o, 32'd0);
    rst_i = 0;
    bus.wb_stb_i = 0; bus.wb_cyc_i = 0; bus.wb_we_i = 0;
    wb_read(32'h14, 32'd0, "rr_cycles");
    wb_read(32'h00, 32'd0, "rr_ctrl");
    wb_read(32'h04, 32'd0, "rr_stat");
    wb_read(32'h0C, 32'd0, "rr_counter");
    wb_read(32'h08, 32'hFFFF_FFFF, "rr_compare");
    wb_read(32'h10, 32'd0, "rr_prescale");
    wb_read(32'h14, 32'd12, "rr_cycles_run");

    // Randomized traffic; the per-cycle monitor compares everything to the model.
    for (int c = 0; c < 4000; c++) begin
      idx = 3'($urandom_range(0, 7));
      case (idx)
        3'd2, 3'd3: begin
          case ($urandom_range(0, 9))
            0:       d = $urandom;
            1:       d = 32'hFFFF_FFFD;
            default: d = 32'($urandom_range(0, 12));
          endcase
        end
        3'd4:    d = ($urandom & 32'hFFFF_0000) | 32'($urandom_range(0, 3));
        default: d = $urandom;
      endcase
      adr = ($urandom & ~32'h1C) | {27'd0, idx, 2'd0};
      bus.wb_adr_i = adr;
      bus.wb_dat_i = d;
      bus.wb_sel_i = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
      bus.wb_we_i  = 1'($urandom_range(0, 1));
      bus.wb_stb_i = ($urandom_range(0, 99) < 60);
      bus.wb_cyc_i = bus.wb_stb_i ? ($urandom_range(0, 9) != 0) : 1'($urandom_range(0, 1));
      rst_i        = ($urandom_range(0, 499) == 0);
      idle(1);
    end
    rst_i = 0;
    bus.wb_stb_i = 0; bus.wb_cyc_i = 0; bus.wb_we_i = 0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_timer.md
WB_TIMER -- requirements
Module: wb_timer

Interface
REQ-001 SHALL have parameter PRESCALE_W, default 16, width of the prescaler reload register and down-counter.
REQ-002 SHALL have port clk_i  input  1  the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset; synchronous to clk_i, active-high.
REQ-004 SHALL have port wb_adr_i  input  32  Wishbone byte address; only bits [4:2] decoded.
REQ-005 SHALL have port wb_dat_i  input  32  write data.
REQ-006 SHALL have port wb_dat_o  output  32  read data, valid while wb_ack_o=1.
REQ-007 SHALL have port wb_sel_i  input  4  byte-lane enables.
REQ-008 SHALL have ports wb_stb_i, wb_cyc_i, wb_we_i  input  1 each  Wishbone strobe, cycle, write enable.
REQ-009 SHALL have port wb_ack_o  output  1  transfer acknowledge.
REQ-010 SHALL have port intr_o  output  1  level interrupt, active-high, registered.

Function
REQ-011 SHALL decode registers (offset): 0x00 CTRL {[0]EN,[1]AR,[2]IRQEN}; 0x04 STAT {[0]MATCH}; 0x08 COMPARE; 0x0C COUNTER; 0x10 PRESCALE [PRESCALE_W-1:0]; 0x14 CYCLES (read-only); 0x18/0x1C read 0, writes ignored.
REQ-012 SHALL assert wb_ack_o exactly one cycle after a clock edge that samples wb_stb_i & wb_cyc_i & ~wb_ack_o, for exactly one cycle; a held strobe yields one ack every second cycle.
REQ-013 SHALL perform the register write on the same edge that raises wb_ack_o; reads return the register value sampled on that edge.
REQ-014 SHALL honour wb_sel_i per byte for COMPARE, COUNTER, PRESCALE; CTRL and STAT use lane 0 only; unused bits read 0.
REQ-015 STAT.MATCH SHALL be write-1-to-clear; writing 0 has no effect.
REQ-016 Prescaler: while EN=1, down-counter pcnt decrements each cycle; when pcnt=0 a one-cycle tick occurs and pcnt reloads from PRESCALE; PRESCALE=0 gives a tick every cycle.
REQ-017 Writing CTRL with EN going 0->1 SHALL reload pcnt from PRESCALE; first tick occurs PRESCALE+1 cycles later.
REQ-018 On a tick with COUNTER != COMPARE: COUNTER <= COUNTER+1, wrapping 0xFFFFFFFF -> 0 without setting MATCH.
REQ-019 On a tick with COUNTER == COMPARE: MATCH <= 1; if AR=1 COUNTER <= 0 and counting continues; if AR=0 COUNTER holds and EN <= 0 (one-shot).
REQ-020 While EN=0 COUNTER and pcnt SHALL hold.
REQ-021 CYCLES SHALL increment every cycle regardless of EN, wrapping modulo 2^32.
REQ-022 intr_o SHALL equal registered (MATCH & IRQEN), i.e. rises one cycle after MATCH sets with IRQEN=1.
REQ-023 Simultaneous STAT W1C and match event: set wins, MATCH stays 1.
REQ-024 Simultaneous COUNTER write and tick: written value wins (per byte lane), pcnt reloads from PRESCALE.
REQ-025 Simultaneous CTRL write clearing EN and one-shot auto-clear: EN=0; written AR/IRQEN take effect.

Reset
REQ-026 On rst_i=1 at a clock edge: CTRL=0, STAT=0, COUNTER=0, CYCLES=0, PRESCALE=0, pcnt=0, COMPARE=0xFFFFFFFF, wb_ack_o=0, intr_o=0, wb_dat_o=0.
REQ-027 Reset asserted mid-transfer SHALL drop wb_ack_o the next edge and discard the write; the master must re-issue.

Verification
REQ-028 PRESCALE=0, COMPARE=3, CTRL=0x7 -> MATCH set on 4th tick after enable, COUNTER 0,1,2,3,0..., intr_o high one cycle after MATCH.
REQ-029 PRESCALE=4, COMPARE=2, CTRL=0x1 (one-shot) -> ticks every 5 cycles, COUNTER stops at 2, EN reads 0, MATCH=1, intr_o stays 0.
REQ-030 COUNTER=0xFFFFFFFE, COMPARE=5, PRESCALE=0, EN=1 -> COUNTER wraps to 0 without MATCH, MATCH at value 5.
REQ-031 STAT write 0x1 on the exact cycle of a match -> MATCH reads 1; a later write 0x1 clears it and intr_o falls one cycle later.
REQ-032 Byte write to COMPARE with wb_sel_i=0x2, data 0x0000AB00, COMPARE=0xFFFFFFFF -> COMPARE=0xFFFFABFF; held wb_stb_i for 6 cycles -> 3 acks.
REQ-033 rst_i asserted during a counting run with MATCH=1 -> next cycle all registers at REQ-026 values, intr_o=0, CYCLES restarts at 0.
